// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between two requesters, with burst limit
// and per-side read-valid strobes. Optional perf counters behind SRAM_ARB_PERF_CNT_EN.
module sram_port_arbiter #(
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 8,
    parameter int BCNT_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_0,
    input  logic        we_0,
    input  logic        req_1,
    input  logic        we_1,
    output logic        gnt_0,
    output logic        gnt_1,
    output logic        sel,
    output logic        cen_0,
    output logic        cen_1,
    output logic        wen_0,
    output logic        wen_1,
    output logic        rvalid_0,
    output logic        rvalid_1
`ifdef SRAM_ARB_PERF_CNT_EN
    ,
    output logic [15:0] conflict_cnt,
    output logic [7:0]  starve_max
`endif
);

    if (MAX_BURST < 1 || MAX_BURST > 2**BCNT_W) begin : g_bad_burst
        $error("sram_port_arbiter: MAX_BURST must be 1..2**BCNT_W");
    end
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
        $error("sram_port_arbiter: RD_LAT must be 1..4");
    end

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(MAX_BURST - 1);

    state_t              state_q, state_d;
    logic                sel_q, sel_d;
    logic                last_q, last_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic [RD_LAT-1:0]   rv_vld_q, rv_vld_d;
    logic [RD_LAT-1:0]   rv_id_q, rv_id_d;

    logic   own_req, oth_req, rd_issue;
    state_t oth_state;

    assign gnt_0    = (state_q == OWN0) & req_0;
    assign gnt_1    = (state_q == OWN1) & req_1;
    assign cen_0    = ~gnt_0;
    assign cen_1    = ~gnt_1;
    assign wen_0    = ~(gnt_0 & we_0);
    assign wen_1    = ~(gnt_1 & we_1);
    assign sel      = sel_q;
    assign rd_issue = (gnt_0 & ~we_0) | (gnt_1 & ~we_1);
    assign rvalid_0 = rv_vld_q[RD_LAT-1] & ~rv_id_q[RD_LAT-1];
    assign rvalid_1 = rv_vld_q[RD_LAT-1] &  rv_id_q[RD_LAT-1];

    assign own_req   = (state_q == OWN1) ? req_1 : req_0;
    assign oth_req   = (state_q == OWN1) ? req_0 : req_1;
    assign oth_state = (state_q == OWN1) ? OWN0 : OWN1;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        bcnt_d  = bcnt_q;
        case (state_q)
            IDLE: begin
                bcnt_d = '0;
                // On a tie, last_q==1 means side 1 went last, so side 0 wins.
                if (req_0 && (!req_1 || last_q)) state_d = OWN0;
                else if (req_1)                  state_d = OWN1;
            end
            OWN0, OWN1: begin
                if (own_req && !(bcnt_q == BCNT_MAX && oth_req)) begin
                    bcnt_d = (bcnt_q == BCNT_MAX) ? bcnt_q : bcnt_q + BCNT_W'(1);
                end else begin
                    bcnt_d  = '0;
                    last_d  = (state_q == OWN1);
                    state_d = oth_req ? oth_state : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        sel_d = sel_q;
        if (state_d == OWN0)      sel_d = 1'b0;
        else if (state_d == OWN1) sel_d = 1'b1;
    end

    // Read-valid shift register: entry at [0], strobe taken from the tail.
    always_comb begin
        rv_vld_d    = rv_vld_q;
        rv_id_d     = rv_id_q;
        rv_vld_d[0] = rd_issue;
        rv_id_d[0]  = sel_q;
        for (int i = 1; i < RD_LAT; i++) begin
            rv_vld_d[i] = rv_vld_q[i-1];
            rv_id_d[i]  = rv_id_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= 1'b0;
            last_q   <= 1'b1;
            bcnt_q   <= '0;
            rv_vld_q <= '0;
            rv_id_q  <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            last_q   <= last_d;
            bcnt_q   <= bcnt_d;
            rv_vld_q <= rv_vld_d;
            rv_id_q  <= rv_id_d;
        end
    end

`ifdef SRAM_ARB_PERF_CNT_EN
    logic [15:0] conflict_q, conflict_d;
    logic [7:0]  run0_q, run0_d, run1_q, run1_d, smax_q, smax_d;
    logic        deny_0, deny_1;

    assign deny_0       = req_0 & ~gnt_0;
    assign deny_1       = req_1 & ~gnt_1;
    assign conflict_cnt = conflict_q;
    assign starve_max   = smax_q;

    always_comb begin
        conflict_d = conflict_q;
        if ((deny_0 | deny_1) && state_q != IDLE && conflict_q != 16'hFFFF)
            conflict_d = conflict_q + 16'd1;
        run0_d = deny_0 ? ((run0_q == 8'hFF) ? run0_q : run0_q + 8'd1) : 8'd0;
        run1_d = deny_1 ? ((run1_q == 8'hFF) ? run1_q : run1_q + 8'd1) : 8'd0;
        smax_d = smax_q;
        if (run0_d > smax_d) smax_d = run0_d;
        if (run1_d > smax_d) smax_d = run1_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_q <= '0;
            run0_q     <= '0;
            run1_q     <= '0;
            smax_q     <= '0;
        end else begin
            conflict_q <= conflict_d;
            run0_q     <= run0_d;
            run1_q     <= run1_d;
            smax_q     <= smax_d;
        end
    end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural arbitration model.
module tb_sram_port_arbiter;
    localparam int RD_LAT    = 3;
    localparam int MAX_BURST = 8;
    localparam int BCNT_W    = 8;

    logic clk = 1'b0;
    logic rst, req_0, we_0, req_1, we_1;
    logic gnt_0, gnt_1, sel, cen_0, cen_1, wen_0, wen_1, rvalid_0, rvalid_1;

    int n_checks = 0;
    int n_fail   = 0;

    sram_port_arbiter #(.RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST), .BCNT_W(BCNT_W)) dut (
        .clk(clk), .rst(rst),
        .req_0(req_0), .we_0(we_0), .req_1(req_1), .we_1(we_1),
        .gnt_0(gnt_0), .gnt_1(gnt_1), .sel(sel),
        .cen_0(cen_0), .cen_1(cen_1), .wen_0(wen_0), .wen_1(wen_1),
        .rvalid_0(rvalid_0), .rvalid_1(rvalid_1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { int due; int id; } rd_t;
    rd_t pend[$];
    int  cyc     = 0;
    int  m_owner = -1;   // -1 idle, else owning side
    int  m_last  = 1;
    int  m_sel   = 0;
    int  m_g     = 0;    // grants given in the current tenure, capped at MAX_BURST

    always @(negedge clk) begin
        logic       e_g0, e_g1, e_rv0, e_rv1, own, oth;
        logic [8:0] e, a;
        int         k;
        cyc++;
        if (rst) begin
            e_g0 = 0; e_g1 = 0; e_rv0 = 0; e_rv1 = 0;
            m_owner = -1; m_last = 1; m_sel = 0; m_g = 0;
            pend.delete();
        end else begin
            e_g0 = (m_owner == 0) && req_0;
            e_g1 = (m_owner == 1) && req_1;
            e_rv0 = 0; e_rv1 = 0;
            foreach (pend[i]) if (pend[i].due == cyc) begin
                if (pend[i].id == 0) e_rv0 = 1; else e_rv1 = 1;
            end
            while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());
            if ((e_g0 && !we_0) || (e_g1 && !we_1))
                pend.push_back('{due: cyc + RD_LAT, id: m_owner});
        end
        e = {e_g0, e_g1, (m_sel != 0), ~e_g0, ~e_g1, ~(e_g0 & we_0), ~(e_g1 & we_1), e_rv0, e_rv1};
        a = {gnt_0, gnt_1, sel, cen_0, cen_1, wen_0, wen_1, rvalid_0, rvalid_1};
        chk("outputs{g0,g1,sel,cen0,cen1,wen0,wen1,rv0,rv1}", 32'(a), 32'(e));
        if (!rst) begin
            if (m_owner < 0) begin
                m_g = 0;
                if (req_0 && req_1) m_owner = 1 - m_last;
                else if (req_0)     m_owner = 0;
                else if (req_1)     m_owner = 1;
            end else begin
                k   = m_owner;
                own = (k == 0) ? req_0 : req_1;
                oth = (k == 0) ? req_1 : req_0;
                if (own) begin
                    if (m_g < MAX_BURST) m_g++;
                    if (m_g == MAX_BURST && oth) begin
                        m_owner = 1 - k; m_last = k; m_g = 0;
                    end
                end else begin
                    m_last = k; m_g = 0;
                    m_owner = oth ? 1 - k : -1;
                end
            end
            if (m_owner >= 0) m_sel = m_owner;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic r0, input logic w0, input logic r1, input logic w1);
        req_0 = r0; we_0 = w0; req_1 = r1; we_1 = w1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0);
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    initial begin
        rst = 1'b1;
        // Reset held with requests toggling
        for (int c = 0; c < 3; c++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
            @(negedge clk);
            chk("rst_gnt", {gnt_0, gnt_1}, 2'b00);
            chk("rst_cen", {cen_0, cen_1}, 2'b11);
            chk("rst_wen", {wen_0, wen_1}, 2'b11);
            chk("rst_rvalid", {rvalid_0, rvalid_1}, 2'b00);
            chk("rst_sel", sel, 1'b0);
            next_cycle();
        end
        rst = 1'b0;

        // Side 0 reads for 4 grants from IDLE
        for (int c = 1; c <= 10; c++) begin
            drive(c <= 5, 0, 0, 0);
            @(negedge clk);
            chk("s2_gnt0", gnt_0, (c >= 2 && c <= 5));
            chk("s2_rvalid0", rvalid_0, (c >= 2 + RD_LAT && c <= 5 + RD_LAT));
            chk("s2_rvalid1", rvalid_1, 1'b0);
            if (c >= 2 && c <= 5) chk("s2_sel", sel, 1'b0);
            next_cycle();
        end

        // Reset one cycle after a read grant drops the in-flight read
        for (int c = 1; c <= 7; c++) begin
            rst = (c == 3 || c == 4);
            drive(c <= 2, 0, c >= 5 && c <= 6, 1);
            @(negedge clk);
            if (c == 2) chk("s6_gnt0", gnt_0, 1'b1);
            if (c >= 3) chk("s6_rvalid0", rvalid_0, 1'b0);
            if (c == 5) chk("s6_idle_after_rst", gnt_1, 1'b0);
            if (c == 6) chk("s6_gnt1", gnt_1, 1'b1);
            next_cycle();
        end
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;

        // Both sides held from reset: 8 grants each, alternating
        for (int c = 1; c <= 20; c++) begin
            drive(1, 0, 1, 0);
            @(negedge clk);
            chk("s3_gnt0", gnt_0, ((c >= 2 && c <= 9) || c >= 18));
            chk("s3_gnt1", gnt_1, (c >= 10 && c <= 17));
            next_cycle();
        end
        idle(RD_LAT + 2);

        // Owner 1 drops mid-burst with side 0 waiting
        for (int c = 1; c <= 8; c++) begin
            drive(c >= 6, 0, c <= 5, 0);
            @(negedge clk);
            if (c >= 2 && c <= 5) chk("s4_gnt1", gnt_1, 1'b1);
            if (c == 6) chk("s4_sel_hold", {sel, gnt_0, gnt_1}, 3'b100);
            if (c == 7) chk("s4_switch", {sel, gnt_0}, 2'b01);
            if (c >= 5) chk("s4_rvalid1", rvalid_1, 1'b1);
            next_cycle();
        end
        idle(RD_LAT + 2);

        // Alternating single reads 0,1,0
        for (int c = 1; c <= 10; c++) begin
            drive(c == 1 || c == 2 || c == 5 || c == 6, 0, c == 3 || c == 4, 0);
            @(negedge clk);
            chk("s5_gnt0", gnt_0, (c == 2 || c == 6));
            chk("s5_gnt1", gnt_1, (c == 4));
            chk("s5_rvalid0", rvalid_0, (c == 2 + RD_LAT || c == 6 + RD_LAT));
            chk("s5_rvalid1", rvalid_1, (c == 4 + RD_LAT));
            next_cycle();
        end

        // Randomized traffic with occasional resets, checked by the model
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1));
            next_cycle();
        end
        rst = 1'b0;
        idle(RD_LAT + 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
